// File: rtl/button_event_pkg.sv
// Shared constants, FSM encoding and pulse bundle for the button event decoder.
package button_event_pkg;

  localparam int unsigned DEF_LONG_CYCLES   = 25_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 5_000_000;
  localparam int unsigned DEF_NUM_MODES     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  typedef struct packed {
    logic press;
    logic rls;
    logic shrt;
    logic lng;
    logic rpt;
  } pulses_t;

endpackage

// File: rtl/button_event_if.sv
// Button input, mode clear and the decoded event/mode outputs.
interface button_event_if #(
  parameter int unsigned MODE_W = 2
);
  logic              btn_level;
  logic              mode_clr;
  logic              press_pulse;
  logic              release_pulse;
  logic              short_pulse;
  logic              long_pulse;
  logic              repeat_pulse;
  logic [MODE_W-1:0] mode_idx;

  modport master (
    output btn_level, mode_clr,
    input  press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, mode_idx
  );

  modport slave (
    input  btn_level, mode_clr,
    output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, mode_idx
  );
endinterface

// File: rtl/hold_timer.sv
// Wrapping cycle counter with clear/enable; term_c flags the last count of LEN.
module hold_timer #(
  parameter int unsigned LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term_c
);
  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign term_c = (cnt_q == CW'(LEN - 1));

  // Wrap at the terminal value so the count never exceeds LEN-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/button_event.sv
// Decodes a debounced button into press/release/short/long/repeat strobes
// and a mode index advanced by short presses.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned NUM_MODES     = DEF_NUM_MODES
) (
  input  logic          clk,
  input  logic          rst,
  button_event_if.slave bus
);
  localparam int unsigned MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  state_e            state_q, state_d;
  pulses_t           pulses_q, pulses_d;
  logic [MODE_W-1:0] mode_idx_q, mode_idx_d;
  logic              btn_q;
  logic              rise_c;
  logic              hold_clr, hold_en, hold_term_c;
  logic              rep_clr, rep_en, rep_term_c;

  assign rise_c = bus.btn_level & ~btn_q;

  hold_timer #(.LEN(LONG_CYCLES)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clr    (hold_clr),
    .en     (hold_en),
    .term_c (hold_term_c)
  );

  hold_timer #(.LEN(REPEAT_CYCLES)) u_rep (
    .clk    (clk),
    .rst    (rst),
    .clr    (rep_clr),
    .en     (rep_en),
    .term_c (rep_term_c)
  );

  // Next state, strobes and mode; release is checked before the long threshold.
  always_comb begin
    state_d    = state_q;
    pulses_d   = '0;
    mode_idx_d = mode_idx_q;
    hold_clr   = 1'b0;
    hold_en    = 1'b0;
    rep_clr    = 1'b0;
    rep_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d        = ST_HELD;
          hold_clr       = 1'b1;
          pulses_d.press = 1'b1;
        end
      end
      ST_HELD: begin
        if (!bus.btn_level) begin
          state_d       = ST_IDLE;
          pulses_d.shrt = 1'b1;
          pulses_d.rls  = 1'b1;
          mode_idx_d    = (mode_idx_q == MODE_W'(NUM_MODES - 1)) ? '0
                                                                  : mode_idx_q + MODE_W'(1);
        end else begin
          hold_en = 1'b1;
          if (hold_term_c) begin
            state_d      = ST_LONG;
            pulses_d.lng = 1'b1;
            rep_clr      = 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (!bus.btn_level) begin
          state_d      = ST_IDLE;
          pulses_d.rls = 1'b1;
        end else begin
          rep_en       = 1'b1;
          pulses_d.rpt = rep_term_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.mode_clr) begin
      mode_idx_d = '0;
    end
  end

  // btn_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pulses_q   <= '0;
      mode_idx_q <= '0;
      btn_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pulses_q   <= pulses_d;
      mode_idx_q <= mode_idx_d;
      btn_q      <= bus.btn_level;
    end
  end

  assign bus.press_pulse   = pulses_q.press;
  assign bus.release_pulse = pulses_q.rls;
  assign bus.short_pulse   = pulses_q.shrt;
  assign bus.long_pulse    = pulses_q.lng;
  assign bus.repeat_pulse  = pulses_q.rpt;
  assign bus.mode_idx      = mode_idx_q;
endmodule
